output_bram_drain: RTL and testbench

Reads back the final accumulated 48-bit results from the PE output BRAM read port once every input channel has been summed. It applies the activation, a rounding right-shift requantization and 16-bit saturation, then streams the pixels out as AXI-Stream with backpressure. This is the readout side of the PE datapath's accumulate-and-write path. It drives the PE's `enb_output_BRAM`/`addrb_output_BRAM` inputs and consumes `BRAM_doutb`.

---
 rtl/output_bram_drain.sv | 152 +++++++++++++++
 tb/tb_output_bram_drain.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_bram_drain.sv
// Reads accumulated results back from the PE output BRAM, applies activation, rounding
// requantization and saturation, then streams the pixels out over AXI-Stream.
module output_bram_drain #(
    parameter int unsigned RESULT_WIDTH = 48,
    parameter int unsigned PIXEL_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH   = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     num_pixels,
    input  logic [5:0]              shift_amt,
    input  logic [1:0]              act_mode,
    output logic                    enb_output_BRAM,
    output logic [ADDR_WIDTH-1:0]   addrb_output_BRAM,
    input  logic [RESULT_WIDTH-1:0] BRAM_doutb,
    output logic [PIXEL_WIDTH-1:0]  m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    localparam logic signed [RESULT_WIDTH:0] SatMax =
        (RESULT_WIDTH+1)'((2 ** (PIXEL_WIDTH-1)) - 1);
    localparam logic signed [RESULT_WIDTH:0] SatMin = -SatMax - 1;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [ADDR_WIDTH:0]             remain_q;
    logic [5:0]                      shift_q;
    logic [1:0]                      act_q;
    logic                            inflight_q, inflight_last_q;
    logic [1:0][PIXEL_WIDTH-1:0]     fifo_data_q;
    logic [1:0]                      fifo_last_q;
    logic                            rd_ptr_q, wr_ptr_q;
    logic [1:0]                      count_q;
    logic                            issue, push, pop, last_read;

    logic signed [RESULT_WIDTH-1:0]  x, y;
    logic signed [RESULT_WIDTH:0]    y_ext, rnd, z;
    logic [PIXEL_WIDTH-1:0]          pix;

    assign push      = inflight_q;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign last_read = (remain_q == (ADDR_WIDTH+1)'(1));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = (num_pixels == '0) ? StDone : StRead;
            end
            StRead: begin
                busy  = 1'b1;
                // Only read when the FIFO is guaranteed a free slot for the returning word.
                issue = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
                if (issue && last_read) state_d = StDrain;
            end
            StDrain: begin
                busy = 1'b1;
                // Leave as the final beat is handshaken so done lands the following cycle.
                if (!inflight_q && (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign enb_output_BRAM   = issue;
    assign addrb_output_BRAM = issue ? addr_q : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            remain_q        <= '0;
            shift_q         <= '0;
            act_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && last_read;
            if (state_q == StIdle && start) begin
                addr_q   <= base_addr;
                remain_q <= num_pixels;
                shift_q  <= shift_amt;
                act_q    <= act_mode;
            end else if (issue) begin
                addr_q   <= addr_q + ADDR_WIDTH'(1);
                remain_q <= remain_q - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    always_comb begin
        x = BRAM_doutb;
        case (act_q)
            2'd1:    y = x[RESULT_WIDTH-1] ? '0 : x;
            2'd2:    y = x[RESULT_WIDTH-1] ? (x >>> 3) : x;
            default: y = x;
        endcase
        y_ext = {y[RESULT_WIDTH-1], y};
        rnd   = '0;
        if (shift_q != 6'd0) rnd = (RESULT_WIDTH+1)'(1) << (shift_q - 6'd1);
        z = (shift_q == 6'd0) ? y_ext : ((y_ext + rnd) >>> shift_q);
        if (z > SatMax) begin
            pix = {1'b0, {(PIXEL_WIDTH-1){1'b1}}};
        end else if (z < SatMin) begin
            pix = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
        end else begin
            pix = z[PIXEL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= pix;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_output_bram_drain.sv
// Randomized self-checking bench for output_bram_drain: BRAM model, stream monitor and an
// arithmetic reference model of the activation / requantization / saturation pipeline.
module tb_output_bram_drain;
    localparam int RW    = 48;
    localparam int PW    = 16;
    localparam int AW    = 14;
    localparam int DEPTH = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_pixels = '0;
    logic [5:0]    shift_amt = '0;
    logic [1:0]    act_mode = '0;
    logic          enb_output_BRAM;
    logic [AW-1:0] addrb_output_BRAM;
    logic [RW-1:0] BRAM_doutb = '0;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;

    output_bram_drain #(.RESULT_WIDTH(RW), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .base_addr         (base_addr),
        .num_pixels        (num_pixels),
        .shift_amt         (shift_amt),
        .act_mode          (act_mode),
        .enb_output_BRAM   (enb_output_BRAM),
        .addrb_output_BRAM (addrb_output_BRAM),
        .BRAM_doutb        (BRAM_doutb),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .busy              (busy),
        .done              (done)
    );

    logic [RW-1:0] mem [DEPTH];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    bit            rand_ready = 1'b0;

    logic [PW-1:0] beat_data [$];
    bit            beat_last [$];
    int            beat_cyc [$];
    int            rd_addr [$];
    int            rd_cyc [$];
    int            done_cyc [$];
    int            viol_stable = 0;
    int            viol_ovf = 0;
    int            outstanding = 0;
    bit            prev_stall = 1'b0;
    logic [PW-1:0] prev_data = '0;
    bit            prev_last = 1'b0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // BRAM read port: data one cycle after enable, garbage otherwise.
    initial begin : bram
        logic [63:0] g;
        forever begin
            @(posedge clk);
            g = {$urandom, $urandom};
            if (enb_output_BRAM) BRAM_doutb <= mem[addrb_output_BRAM];
            else BRAM_doutb <= g[RW-1:0];
        end
    end

    initial begin : ready_gen
        int stall;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                if (stall > 0) begin
                    m_axis_tready = 1'b0;
                    stall--;
                end else if ($urandom_range(0, 5) == 0) begin
                    m_axis_tready = 1'b0;
                    stall = 4;
                end else begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: records reads, beats and done pulses; counts protocol violations.
    initial forever begin : monitor
        int pop;
        @(negedge clk);
        if (!rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            pop = (m_axis_tvalid && m_axis_tready) ? 1 : 0;
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                               m_axis_tlast !== prev_last)) viol_stable++;
            if (enb_output_BRAM) begin
                if (outstanding >= 2 + pop) viol_ovf++;
                rd_addr.push_back(int'(addrb_output_BRAM));
                rd_cyc.push_back(cyc);
                outstanding++;
            end
            if (pop == 1) begin
                beat_data.push_back(m_axis_tdata);
                beat_last.push_back(m_axis_tlast);
                beat_cyc.push_back(cyc);
                outstanding--;
            end
            if (done) done_cyc.push_back(cyc);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [PW-1:0] ref_pixel(input logic [RW-1:0] raw, input int s,
                                                input int m);
        longint x, y, q;
        x = longint'($signed(raw));
        if (m == 1) y = (x < 0) ? 0 : x;
        else if (m == 2) y = (x < 0) ? floor_div(x, 8) : x;
        else y = x;
        if (s == 0) q = y;
        else q = floor_div(y + (longint'(1) << (s - 1)), longint'(1) << s);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[PW-1:0];
    endfunction

    function automatic logic [RW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        r = $signed(r) >>> $urandom_range(16, 40);
        return r[RW-1:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        rd_addr.delete();
        rd_cyc.delete();
        done_cyc.delete();
        viol_stable = 0;
        viol_ovf    = 0;
    endtask

    task automatic start_drain(input int b, input int n, input int s, input int m);
        base_addr  = AW'(b);
        num_pixels = (AW+1)'(n);
        shift_amt  = 6'(s);
        act_mode   = 2'(m);
        start      = 1'b1;
        start_cyc  = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        checks++;
        if ({enb_output_BRAM, addrb_output_BRAM, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
             busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got enb=%b addr=%h tvalid=%b tlast=%b tdata=%h busy=%b done=%b, want all 0",
                     enb_output_BRAM, addrb_output_BRAM, m_axis_tvalid, m_axis_tlast,
                     m_axis_tdata, busy, done);
        end
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_requant();
        bit ok;
        int s;
        clear_mon();
        mem[0] = 48'h0000_0001_2380;
        start_drain(0, 1, 8, 0);
        s = start_cyc;
        wait_done(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL requant_done: got no done, want done"); end
        checks++;
        if (beat_data.size() != 1) begin
            errors++; $display("FAIL requant_beats: got %0d, want 1", beat_data.size());
        end
        if (beat_data.size() > 0 && rd_cyc.size() > 0 && done_cyc.size() > 0) begin
            checks++;
            if (beat_data[0] !== 16'h0124 || beat_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL requant_beat: got %h/%b, want 0124/1", beat_data[0], beat_last[0]);
            end
            checks++;
            if (rd_cyc[0] != s + 1 || beat_cyc[0] != rd_cyc[0] + 2) begin
                errors++;
                $display("FAIL requant_latency: got read@%0d beat@%0d, want read@%0d beat@%0d",
                         rd_cyc[0], beat_cyc[0], s + 1, s + 3);
            end
            checks++;
            if (done_cyc[0] != beat_cyc[0] + 1) begin
                errors++;
                $display("FAIL requant_done_timing: got %0d, want %0d", done_cyc[0],
                         beat_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        clear_mon();
        mem[0] = 48'h0000_0100_0000;
        mem[1] = 48'hFFFF_FF00_0000;
        start_drain(0, 2, 8, 0);
        wait_done(50, ok);
        checks++;
        if (!ok || beat_data.size() != 2) begin
            errors++; $display("FAIL sat_beats: got %0d beats, want 2", beat_data.size());
        end else begin
            checks++;
            if (beat_data[0] !== 16'h7FFF || beat_data[1] !== 16'h8000) begin
                errors++;
                $display("FAIL sat_data: got %h %h, want 7fff 8000", beat_data[0], beat_data[1]);
            end
            checks++;
            if (beat_last[0] !== 1'b0 || beat_last[1] !== 1'b1) begin
                errors++;
                $display("FAIL sat_last: got %b%b, want 01", beat_last[0], beat_last[1]);
            end
        end
    endtask

    task automatic test_activation();
        bit            ok;
        int            modes [3] = '{1, 2, 3};
        logic [PW-1:0] want [3] = '{16'h0000, 16'hFF83, 16'hFC18};
        mem[5] = 48'hFFFF_FFFF_FC18;
        for (int i = 0; i < 3; i++) begin
            clear_mon();
            start_drain(5, 1, 0, modes[i]);
            wait_done(50, ok);
            checks++;
            if (!ok || beat_data.size() != 1) begin
                errors++;
                $display("FAIL act_mode%0d_beats: got %0d, want 1", modes[i], beat_data.size());
            end else if (beat_data[0] !== want[i]) begin
                errors++;
                $display("FAIL act_mode%0d: got %h, want %h", modes[i], beat_data[0], want[i]);
            end
        end
    endtask

    task automatic test_wrap_throughput();
        bit ok;
        int s, m;
        s = $urandom_range(0, 20);
        m = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) mem[(16382 + i) % DEPTH] = rand_word();
        clear_mon();
        start_drain(16382, 4, s, m);
        wait_done(50, ok);
        checks++;
        if (!ok || rd_addr.size() != 4 || beat_data.size() != 4) begin
            errors++;
            $display("FAIL wrap_counts: got %0d reads %0d beats, want 4 4", rd_addr.size(),
                     beat_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_addr[i] != (16382 + i) % DEPTH || rd_cyc[i] != rd_cyc[0] + i) begin
                    errors++;
                    $display("FAIL wrap_read%0d: got %h@%0d, want %h@%0d", i, rd_addr[i],
                             rd_cyc[i], (16382 + i) % DEPTH, rd_cyc[0] + i);
                end
                checks++;
                if (beat_data[i] !== ref_pixel(mem[(16382 + i) % DEPTH], s, m) ||
                    beat_last[i] !== (i == 3) || beat_cyc[i] != rd_cyc[0] + 2 + i) begin
                    errors++;
                    $display("FAIL wrap_beat%0d: got %h/%b@%0d, want %h/%b@%0d", i,
                             beat_data[i], beat_last[i], beat_cyc[i],
                             ref_pixel(mem[(16382 + i) % DEPTH], s, m), i == 3,
                             rd_cyc[0] + 2 + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int b, s, m;
        b = $urandom_range(0, DEPTH - 1);
        s = $urandom_range(0, 24);
        m = $urandom_range(0, 3);
        for (int i = 0; i < 16; i++) mem[(b + i) % DEPTH] = rand_word();
        clear_mon();
        rand_ready = 1'b1;
        start_drain(b, 16, s, m);
        wait_done(2000, ok);
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;
        checks++;
        if (!ok || beat_data.size() != 16 || rd_addr.size() != 16) begin
            errors++;
            $display("FAIL bp_counts: got %0d beats %0d reads, want 16 16", beat_data.size(),
                     rd_addr.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (beat_data[i] !== ref_pixel(mem[(b + i) % DEPTH], s, m) ||
                    beat_last[i] !== (i == 15) || rd_addr[i] != (b + i) % DEPTH) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got %h/%b addr %h, want %h/%b addr %h", i,
                             beat_data[i], beat_last[i], rd_addr[i],
                             ref_pixel(mem[(b + i) % DEPTH], s, m), i == 15, (b + i) % DEPTH);
                end
            end
        end
        checks++;
        if (viol_stable != 0 || viol_ovf != 0) begin
            errors++;
            $display("FAIL bp_protocol: got %0d stability %0d overflow violations, want 0 0",
                     viol_stable, viol_ovf);
        end
    endtask

    task automatic test_random_drains();
        bit ok;
        int b, n, s, m;
        for (int k = 0; k < 4; k++) begin
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 12);
            s = $urandom_range(0, 47);
            m = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) mem[(b + i) % DEPTH] = rand_word();
            clear_mon();
            start_drain(b, n, s, m);
            wait_done(100, ok);
            checks++;
            if (!ok || beat_data.size() != n) begin
                errors++;
                $display("FAIL rand%0d_beats: got %0d, want %0d", k, beat_data.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (beat_data[i] !== ref_pixel(mem[(b + i) % DEPTH], s, m) ||
                        beat_last[i] !== (i == n - 1)) begin
                        errors++;
                        $display("FAIL rand%0d_beat%0d: got %h/%b, want %h/%b", k, i,
                                 beat_data[i], beat_last[i],
                                 ref_pixel(mem[(b + i) % DEPTH], s, m), i == n - 1);
                    end
                end
            end
        end
    endtask

    task automatic test_zero_pixels();
        bit ok;
        clear_mon();
        start_drain(7, 0, 0, 0);
        wait_done(10, ok);
        checks++;
        if (!ok || beat_data.size() != 0 || rd_addr.size() != 0 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL zero_counts: got %0d beats %0d reads %0d dones, want 0 0 1",
                     beat_data.size(), rd_addr.size(), done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != start_cyc + 1) begin
                errors++;
                $display("FAIL zero_done_timing: got %0d, want %0d", done_cyc[0], start_cyc + 1);
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        for (int i = 0; i < 6; i++) mem[100 + i] = rand_word();
        clear_mon();
        m_axis_tready = 1'b0;
        start_drain(100, 6, 4, 1);
        tick(3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b, want 1", busy); end
        start_drain(300, 2, 0, 0);
        tick(2);
        m_axis_tready = 1'b1;
        wait_done(100, ok);
        checks++;
        if (!ok || beat_data.size() != 6 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL busy_start_counts: got %0d beats %0d dones, want 6 1",
                     beat_data.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (beat_data[i] !== ref_pixel(mem[100 + i], 4, 1)) begin
                    errors++;
                    $display("FAIL busy_start_beat%0d: got %h, want %h", i, beat_data[i],
                             ref_pixel(mem[100 + i], 4, 1));
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        bit seen;
        for (int i = 0; i < 8; i++) mem[500 + i] = rand_word();
        for (int i = 0; i < 3; i++) mem[700 + i] = rand_word();
        clear_mon();
        m_axis_tready = 1'b0;
        start_drain(500, 8, 3, 2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1);
            seen = m_axis_tvalid;
        end
        tick(5);
        checks++;
        if (!seen || rd_addr.size() != 2 || viol_ovf != 0) begin
            errors++;
            $display("FAIL stall_reads: got tvalid=%b reads=%0d ovf=%0d, want 1 2 0", seen,
                     rd_addr.size(), viol_ovf);
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (m_axis_tvalid !== 1'b0 || enb_output_BRAM !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got tvalid=%b enb=%b busy=%b, want 0 0 0", m_axis_tvalid,
                     enb_output_BRAM, busy);
        end
        rst = 1'b1;
        m_axis_tready = 1'b1;
        tick(1);
        clear_mon();
        start_drain(700, 3, 2, 0);
        wait_done(50, ok);
        checks++;
        if (!ok || beat_data.size() != 3 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL after_reset_counts: got %0d beats %0d dones, want 3 1",
                     beat_data.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beat_data[i] !== ref_pixel(mem[700 + i], 2, 0) ||
                    beat_last[i] !== (i == 2)) begin
                    errors++;
                    $display("FAIL after_reset_beat%0d: got %h/%b, want %h/%b", i, beat_data[i],
                             beat_last[i], ref_pixel(mem[700 + i], 2, 0), i == 2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_requant();
        test_saturation();
        test_activation();
        test_wrap_throughput();
        test_backpressure();
        test_random_drains();
        test_zero_pixels();
        test_start_while_busy();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
